// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if
//   Bundles the programmable timing inputs and the generated timing outputs of
//   video_timing_gen.
//   master : generator side (reads timing values, drives sync/position/strobes)
//   slave  : consumer side (draw logic / register block)
//   Timing inputs : HActive, HFrontPorch, HSynchPulse, HBackPorch (XW bits, pixels)
//                   VActive, VFrontPorch, VSynchPulse, VBackPorch (YW bits, lines)
//   Outputs       : hsync, vsync, video_on, xposition, yposition,
//                   LineEnd, FrameEnd, frame_count
interface video_timing_gen_if #(
  parameter int XW  = 10,
  parameter int YW  = 10,
  parameter int FCW = 8
);
  logic [XW-1:0]  HActive;
  logic [XW-1:0]  HFrontPorch;
  logic [XW-1:0]  HSynchPulse;
  logic [XW-1:0]  HBackPorch;
  logic [YW-1:0]  VActive;
  logic [YW-1:0]  VFrontPorch;
  logic [YW-1:0]  VSynchPulse;
  logic [YW-1:0]  VBackPorch;

  logic           hsync;
  logic           vsync;
  logic           video_on;
  logic [XW-1:0]  xposition;
  logic [YW-1:0]  yposition;
  logic           LineEnd;
  logic           FrameEnd;
  logic [FCW-1:0] frame_count;

  modport master (
    input  HActive, HFrontPorch, HSynchPulse, HBackPorch,
    input  VActive, VFrontPorch, VSynchPulse, VBackPorch,
    output hsync, vsync, video_on, xposition, yposition,
    output LineEnd, FrameEnd, frame_count
  );

  modport slave (
    output HActive, HFrontPorch, HSynchPulse, HBackPorch,
    output VActive, VFrontPorch, VSynchPulse, VBackPorch,
    input  hsync, vsync, video_on, xposition, yposition,
    input  LineEnd, FrameEnd, frame_count
  );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Programmable horizontal + vertical video timing generator. A pixel tick is
//   recovered from the asynchronous PixelClock square wave; on each tick the
//   x/y counters step through Active / FrontPorch / Sync / BackPorch.
//   Ports:
//     clock      system clock, all state on the rising edge
//     reset      synchronous, active-high
//     PixelClock asynchronous pixel-rate square wave (slower than clock/4)
//     vif        video_timing_gen_if.master: timing inputs, sync/position
//                outputs, LineEnd/FrameEnd strobes, frame_count
module video_timing_gen #(
  parameter int XW        = 10,
  parameter int YW        = 10,
  parameter int FCW       = 8,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter bit TICK_EDGE = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                PixelClock,
  video_timing_gen_if.master  vif
);

  localparam int HTW = XW + 2;
  localparam int VTW = YW + 2;

  localparam logic [HTW-1:0] H_CAP = HTW'(1) << XW;
  localparam logic [VTW-1:0] V_CAP = VTW'(1) << YW;
  localparam logic [XW:0]    H_ONE = (XW+1)'(1);
  localparam logic [YW:0]    V_ONE = (YW+1)'(1);

  // PixelClock synchroniser and edge detector
  logic pix_s1, pix_s2, pix_d;
  logic tick;

  // timing shadows, only updated at reset and at the frame wrap
  logic [XW-1:0] sh_ha, sh_hfp, sh_hsp, sh_hbp;
  logic [YW-1:0] sh_va, sh_vfp, sh_vsp, sh_vbp;

  logic [XW-1:0]  x_q;
  logic [YW-1:0]  y_q;
  logic           hsync_q, vsync_q, video_on_q;
  logic           line_end_q, frame_end_q;
  logic [FCW-1:0] frame_cnt_q;

  logic [HTW-1:0] h_sum;
  logic [VTW-1:0] v_sum;
  logic [XW:0]    h_tot, h_last;
  logic [YW:0]    v_tot, v_last;
  logic           x_wrap, y_wrap, frame_wrap;
  logic [XW-1:0]  x_nxt;
  logic [YW-1:0]  y_nxt;

  logic [XW-1:0]  e_ha, e_hfp, e_hsp;
  logic [YW-1:0]  e_va, e_vfp, e_vsp;
  logic [HTW-1:0] hs_start, hs_end, x_ext;
  logic [VTW-1:0] vs_start, vs_end, y_ext;
  logic           hs_act, vs_act, vid_nxt;

  assign tick = TICK_EDGE ? (pix_s2 & ~pix_d) : (~pix_s2 & pix_d);

  // totals: saturate at 2^W, and a zero total behaves as a one-pixel line/frame
  assign h_sum = HTW'(sh_ha) + HTW'(sh_hfp) + HTW'(sh_hsp) + HTW'(sh_hbp);
  assign v_sum = VTW'(sh_va) + VTW'(sh_vfp) + VTW'(sh_vsp) + VTW'(sh_vbp);

  always_comb begin
    h_tot = h_sum[XW:0];
    if (h_sum > H_CAP) begin
      h_tot = H_CAP[XW:0];
    end else if (h_sum == '0) begin
      h_tot = H_ONE;
    end
  end

  always_comb begin
    v_tot = v_sum[YW:0];
    if (v_sum > V_CAP) begin
      v_tot = V_CAP[YW:0];
    end else if (v_sum == '0) begin
      v_tot = V_ONE;
    end
  end

  assign h_last = h_tot - H_ONE;
  assign v_last = v_tot - V_ONE;

  assign x_wrap     = ({1'b0, x_q} == h_last);
  assign y_wrap     = ({1'b0, y_q} == v_last);
  assign frame_wrap = x_wrap & y_wrap;

  always_comb begin
    x_nxt = x_q + XW'(1);
    y_nxt = y_q;
    if (x_wrap) begin
      x_nxt = '0;
      y_nxt = y_wrap ? '0 : (y_q + YW'(1));
    end
  end

  // The first pixel of a new frame already belongs to the freshly loaded
  // timing, so its sync/video_on levels are decoded from the inputs that are
  // being captured into the shadows on the same edge.
  always_comb begin
    e_ha  = sh_ha;
    e_hfp = sh_hfp;
    e_hsp = sh_hsp;
    e_va  = sh_va;
    e_vfp = sh_vfp;
    e_vsp = sh_vsp;
    if (frame_wrap) begin
      e_ha  = vif.HActive;
      e_hfp = vif.HFrontPorch;
      e_hsp = vif.HSynchPulse;
      e_va  = vif.VActive;
      e_vfp = vif.VFrontPorch;
      e_vsp = vif.VSynchPulse;
    end
  end

  always_comb begin
    x_ext    = HTW'(x_nxt);
    y_ext    = VTW'(y_nxt);
    hs_start = HTW'(e_ha) + HTW'(e_hfp);
    hs_end   = hs_start + HTW'(e_hsp);
    vs_start = VTW'(e_va) + VTW'(e_vfp);
    vs_end   = vs_start + VTW'(e_vsp);
    hs_act   = (x_ext >= hs_start) && (x_ext < hs_end);
    vs_act   = (y_ext >= vs_start) && (y_ext < vs_end);
    vid_nxt  = (x_nxt < e_ha) && (y_nxt < e_va);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // all three flops follow PixelClock so release cannot fake an edge
      pix_s1      <= PixelClock;
      pix_s2      <= PixelClock;
      pix_d       <= PixelClock;
      sh_ha       <= vif.HActive;
      sh_hfp      <= vif.HFrontPorch;
      sh_hsp      <= vif.HSynchPulse;
      sh_hbp      <= vif.HBackPorch;
      sh_va       <= vif.VActive;
      sh_vfp      <= vif.VFrontPorch;
      sh_vsp      <= vif.VSynchPulse;
      sh_vbp      <= vif.VBackPorch;
      x_q         <= '0;
      y_q         <= '0;
      hsync_q     <= ~HSYNC_POL;
      vsync_q     <= ~VSYNC_POL;
      video_on_q  <= (vif.HActive != '0) && (vif.VActive != '0);
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      pix_s1      <= PixelClock;
      pix_s2      <= pix_s1;
      pix_d       <= pix_s2;
      line_end_q  <= tick & x_wrap;
      frame_end_q <= tick & frame_wrap;
      if (tick) begin
        x_q        <= x_nxt;
        y_q        <= y_nxt;
        hsync_q    <= hs_act ? HSYNC_POL : ~HSYNC_POL;
        vsync_q    <= vs_act ? VSYNC_POL : ~VSYNC_POL;
        video_on_q <= vid_nxt;
        if (frame_wrap) begin
          frame_cnt_q <= frame_cnt_q + FCW'(1);
          sh_ha       <= vif.HActive;
          sh_hfp      <= vif.HFrontPorch;
          sh_hsp      <= vif.HSynchPulse;
          sh_hbp      <= vif.HBackPorch;
          sh_va       <= vif.VActive;
          sh_vfp      <= vif.VFrontPorch;
          sh_vsp      <= vif.VSynchPulse;
          sh_vbp      <= vif.VBackPorch;
        end
      end
    end
  end

  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.video_on    = video_on_q;
  assign vif.xposition   = x_q;
  assign vif.yposition   = y_q;
  assign vif.LineEnd     = line_end_q;
  assign vif.FrameEnd    = frame_end_q;
  assign vif.frame_count = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
//   Drives two generators from one PixelClock: dut_a advances on the falling
//   edge with active-low syncs, dut_b on the rising edge with active-high
//   syncs. A per-pixel reference model predicts every output after each
//   PixelClock half period.
module tb_video_timing_gen;
  localparam int XW  = 10;
  localparam int YW  = 10;
  localparam int FCW = 8;

  typedef struct {
    int ha, hfp, hsp, hbp;
    int va, vfp, vsp, vbp;
  } cfg_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic pix   = 1'b0;

  always #5 clock = ~clock;

  video_timing_gen_if #(.XW(XW), .YW(YW), .FCW(FCW)) ifa ();
  video_timing_gen_if #(.XW(XW), .YW(YW), .FCW(FCW)) ifb ();

  video_timing_gen #(.XW(XW), .YW(YW), .FCW(FCW),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .TICK_EDGE(1'b0)) dut_a (
    .clock(clock), .reset(reset), .PixelClock(pix), .vif(ifa.master));

  video_timing_gen #(.XW(XW), .YW(YW), .FCW(FCW),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .TICK_EDGE(1'b1)) dut_b (
    .clock(clock), .reset(reset), .PixelClock(pix), .vif(ifb.master));

  int checks = 0;
  int errors = 0;

  // reference model state, index 0 = dut_a, 1 = dut_b
  cfg_t cur;
  cfg_t sh [2];
  int   mx [2];
  int   my [2];
  int   mfc[2];
  bit   ehs[2], evs[2], evid[2], ele[2], efe[2];

  function automatic int total(int a, int b, int c, int d, int w);
    int s;
    s = a + b + c + d;
    if (s > (1 << w)) s = 1 << w;
    if (s == 0) s = 1;
    return s;
  endfunction

  task automatic check(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, d, obs, exp);
    end
  endtask

  task automatic apply_cfg(cfg_t c);
    cur = c;
    ifa.HActive = XW'(c.ha); ifa.HFrontPorch = XW'(c.hfp);
    ifa.HSynchPulse = XW'(c.hsp); ifa.HBackPorch = XW'(c.hbp);
    ifa.VActive = YW'(c.va); ifa.VFrontPorch = YW'(c.vfp);
    ifa.VSynchPulse = YW'(c.vsp); ifa.VBackPorch = YW'(c.vbp);
    ifb.HActive = XW'(c.ha); ifb.HFrontPorch = XW'(c.hfp);
    ifb.HSynchPulse = XW'(c.hsp); ifb.HBackPorch = XW'(c.hbp);
    ifb.VActive = YW'(c.va); ifb.VFrontPorch = YW'(c.vfp);
    ifb.VSynchPulse = YW'(c.vsp); ifb.VBackPorch = YW'(c.vbp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      sh[d]   = cur;
      mx[d]   = 0;
      my[d]   = 0;
      mfc[d]  = 0;
      ehs[d]  = 1'b0;
      evs[d]  = 1'b0;
      evid[d] = (cur.ha != 0) && (cur.va != 0);
      ele[d]  = 1'b0;
      efe[d]  = 1'b0;
    end
  endtask

  task automatic model_tick(int d);
    int ht, vt, hs0, vs0;
    ht = total(sh[d].ha, sh[d].hfp, sh[d].hsp, sh[d].hbp, XW);
    vt = total(sh[d].va, sh[d].vfp, sh[d].vsp, sh[d].vbp, YW);
    ele[d] = 1'b0;
    efe[d] = 1'b0;
    if (mx[d] == ht - 1) begin
      mx[d]  = 0;
      ele[d] = 1'b1;
      if (my[d] == vt - 1) begin
        my[d]  = 0;
        efe[d] = 1'b1;
        mfc[d] = (mfc[d] + 1) % (1 << FCW);
        sh[d]  = cur;
      end else begin
        my[d] = my[d] + 1;
      end
    end else begin
      mx[d] = mx[d] + 1;
    end
    hs0     = sh[d].ha + sh[d].hfp;
    vs0     = sh[d].va + sh[d].vfp;
    ehs[d]  = (mx[d] >= hs0) && (mx[d] < hs0 + sh[d].hsp);
    evs[d]  = (my[d] >= vs0) && (my[d] < vs0 + sh[d].vsp);
    evid[d] = (mx[d] < sh[d].ha) && (my[d] < sh[d].va);
  endtask

  task automatic check_all();
    logic [31:0] ox, oy, ohs, ovs, ov, ole, ofe, ofc;
    bit lh, lv;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        ox = 32'(ifa.xposition); oy = 32'(ifa.yposition);
        ohs = 32'(ifa.hsync); ovs = 32'(ifa.vsync); ov = 32'(ifa.video_on);
        ole = 32'(ifa.LineEnd); ofe = 32'(ifa.FrameEnd); ofc = 32'(ifa.frame_count);
        lh = !ehs[d]; lv = !evs[d];
      end else begin
        ox = 32'(ifb.xposition); oy = 32'(ifb.yposition);
        ohs = 32'(ifb.hsync); ovs = 32'(ifb.vsync); ov = 32'(ifb.video_on);
        ole = 32'(ifb.LineEnd); ofe = 32'(ifb.FrameEnd); ofc = 32'(ifb.frame_count);
        lh = ehs[d]; lv = evs[d];
      end
      check("xposition",   d, ox,  32'(mx[d]));
      check("yposition",   d, oy,  32'(my[d]));
      check("hsync",       d, ohs, 32'(lh));
      check("vsync",       d, ovs, 32'(lv));
      check("video_on",    d, ov,  32'(evid[d]));
      check("LineEnd",     d, ole, 32'(ele[d]));
      check("FrameEnd",    d, ofe, 32'(efe[d]));
      check("frame_count", d, ofc, 32'(mfc[d]));
    end
  endtask

  // one PixelClock half period of 4 clocks; outputs are checked 3 clocks
  // after the edge, the clock on which any strobe is still high
  task automatic half();
    int d;
    pix = ~pix;
    d = pix ? 1 : 0;
    model_tick(d);
    ele[1-d] = 1'b0;
    efe[1-d] = 1'b0;
    repeat (3) @(negedge clock);
    check_all();
    @(negedge clock);
  endtask

  task automatic run_halves(int n);
    repeat (n) half();
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    repeat (n) @(negedge clock);
    model_reset();
    check_all();
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check_all();
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.ha  = $urandom_range(6, 1);
    c.hfp = $urandom_range(4, 0);
    c.hsp = $urandom_range(4, 0);
    c.hbp = $urandom_range(4, 0);
    c.va  = $urandom_range(3, 1);
    c.vfp = $urandom_range(2, 0);
    c.vsp = $urandom_range(2, 0);
    c.vbp = $urandom_range(2, 0);
    return c;
  endfunction

  initial begin
    cfg_t c;
    @(negedge clock);

    // 640x480 timing: one full line plus part of the next
    c = '{ha: 640, hfp: 16, hsp: 96, hbp: 48, va: 480, vfp: 10, vsp: 2, vbp: 33};
    apply_cfg(c);
    pix = 1'b0;
    do_reset(3);
    run_halves(2 * 850);

    // random small timings, reset taken with PixelClock high,
    // new inputs mid-frame only take effect after FrameEnd
    for (int r = 0; r < 3; r++) begin
      apply_cfg(rand_cfg());
      pix = 1'b1;
      do_reset(2);
      run_halves(200);
      apply_cfg(rand_cfg());
      run_halves(500);
      if (r == 2) begin
        // single-clock reset in the middle of a frame
        do_reset(1);
        run_halves(150);
      end
    end

    // saturating horizontal total (1100 -> 1024), no sync pulse, V total 0
    c = '{ha: 600, hfp: 300, hsp: 0, hbp: 200, va: 0, vfp: 0, vsp: 0, vbp: 0};
    apply_cfg(c);
    do_reset(2);
    run_halves(2 * 1030);

    // all-zero timing: counters pinned at 0, strobes every tick
    c = '{ha: 0, hfp: 0, hsp: 0, hbp: 0, va: 0, vfp: 0, vsp: 0, vbp: 0};
    apply_cfg(c);
    do_reset(2);
    run_halves(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
